// File: rtl/hazard_unit_pkg.sv
// hazard_unit_pkg: shared pipeline definitions for the hazard unit.
//   REG_W        register-number width
//   REG_ZERO     register 0, which never carries a dependency
//   mdu_state_e  MDU tracker FSM state encoding
//   src_hit()    does the ID instruction actually read register r?
package hazard_unit_pkg;

  localparam int REG_W = 5;
  localparam logic [REG_W-1:0] REG_ZERO = 5'd0;

  typedef enum logic {
    MDU_IDLE = 1'b0,
    MDU_BUSY = 1'b1
  } mdu_state_e;

  function automatic logic src_hit(
    input logic [REG_W-1:0] r,
    input logic [REG_W-1:0] rs,
    input logic [REG_W-1:0] rt,
    input logic             use_rs,
    input logic             use_rt
  );
    return (r != REG_ZERO) && ((use_rs && (rs == r)) || (use_rt && (rt == r)));
  endfunction

endpackage

// File: rtl/hazard_unit_if.sv
// hazard_unit_if: bundle between the pipeline (master) and the hazard unit (slave).
//   ID side : id_valid, rs_id, rt_id, uses_rs, uses_rt, id_is_mdu
//   EX side : memRead_ex, regWrite_ex, rd_ex, mdu_start, mdu_rd, flush
//   outputs : stall_pc, stall_ifid, bubble_idex, mdu_busy, mdu_done,
//             mdu_rd_wb, mdu_overrun, stall_cycles
// Handshake: there is no valid/ready pair here. id_valid qualifies the ID
// fields in the same cycle; mdu_start is a single-cycle strobe sampled on the
// rising edge and is never back-pressured (a start while busy is dropped and
// flagged through mdu_overrun).
interface hazard_unit_if
  import hazard_unit_pkg::*;
#(
  parameter int CNT_W = 16
);
  logic             id_valid;
  logic [REG_W-1:0] rs_id;
  logic [REG_W-1:0] rt_id;
  logic             uses_rs;
  logic             uses_rt;
  logic             id_is_mdu;
  logic             memRead_ex;
  logic             regWrite_ex;
  logic [REG_W-1:0] rd_ex;
  logic             mdu_start;
  logic [REG_W-1:0] mdu_rd;
  logic             flush;

  logic             stall_pc;
  logic             stall_ifid;
  logic             bubble_idex;
  logic             mdu_busy;
  logic             mdu_done;
  logic [REG_W-1:0] mdu_rd_wb;
  logic             mdu_overrun;
  logic [CNT_W-1:0] stall_cycles;

  modport master (
    output id_valid, rs_id, rt_id, uses_rs, uses_rt, id_is_mdu,
           memRead_ex, regWrite_ex, rd_ex, mdu_start, mdu_rd, flush,
    input  stall_pc, stall_ifid, bubble_idex, mdu_busy, mdu_done,
           mdu_rd_wb, mdu_overrun, stall_cycles
  );

  modport slave (
    input  id_valid, rs_id, rt_id, uses_rs, uses_rt, id_is_mdu,
           memRead_ex, regWrite_ex, rd_ex, mdu_start, mdu_rd, flush,
    output stall_pc, stall_ifid, bubble_idex, mdu_busy, mdu_done,
           mdu_rd_wb, mdu_overrun, stall_cycles
  );
endinterface

// File: rtl/hazard_unit_mdu_tracker.sv
// mdu_tracker: countdown for the multi-cycle MDU result.
//   i_start/i_rd  MDU op leaves EX this cycle, with its destination
//   o_busy        result outstanding (state == BUSY)
//   o_pend_rd     destination of the outstanding op
//   o_done        one-cycle pulse in the last busy cycle, o_rd_wb alongside
//   o_overrun     sticky: a start arrived while busy and was dropped
//   o_state       FSM state for observation
module mdu_tracker
  import hazard_unit_pkg::*;
#(
  parameter int MDU_LAT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_start,
  input  logic [REG_W-1:0] i_rd,
  output logic             o_busy,
  output logic [REG_W-1:0] o_pend_rd,
  output logic             o_done,
  output logic [REG_W-1:0] o_rd_wb,
  output logic             o_overrun,
  output mdu_state_e       o_state
);

  localparam logic [3:0] LAT = 4'(MDU_LAT);

  mdu_state_e       r_state;
  logic [3:0]       r_cnt;
  logic [REG_W-1:0] r_pend_rd;
  logic             r_done;
  logic [REG_W-1:0] r_rd_wb;
  logic             r_overrun;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= MDU_IDLE;
      r_cnt     <= 4'd0;
      r_pend_rd <= REG_ZERO;
      r_done    <= 1'b0;
      r_rd_wb   <= REG_ZERO;
      r_overrun <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        MDU_IDLE: begin
          if (i_start) begin
            r_state   <= MDU_BUSY;
            r_cnt     <= LAT;
            r_pend_rd <= i_rd;
          end
        end
        MDU_BUSY: begin
          r_cnt <= r_cnt - 4'd1;
          // A start here is dropped; count and destination stay put.
          if (i_start) r_overrun <= 1'b1;
          // Done is registered one edge early so it is high exactly while
          // cnt == 1; MDU_LAT >= 2 guarantees that edge exists.
          if (r_cnt == 4'd2) begin
            r_done  <= 1'b1;
            r_rd_wb <= r_pend_rd;
          end
          if (r_cnt == 4'd1) r_state <= MDU_IDLE;
        end
        default: r_state <= MDU_IDLE;
      endcase
    end
  end

  assign o_busy    = (r_state == MDU_BUSY);
  assign o_pend_rd = r_pend_rd;
  assign o_done    = r_done;
  assign o_rd_wb   = r_rd_wb;
  assign o_overrun = r_overrun;
  assign o_state   = r_state;

endmodule

// File: rtl/hazard_unit.sv
// hazard_unit: stall/bubble generator beside the ID stage.
//   clk, rst_n   pipeline clock, async active-low reset
//   hz           hazard_unit_if slave port (ID/EX inputs, stall/MDU outputs)
//   o_dbg_state  MDU tracker FSM state
// Detects load-use and MDU (data and structural) hazards that forwarding
// cannot cover. Stall and bubble are combinational; flush beats stall because
// the ID instruction is being squashed anyway.
module hazard_unit
  import hazard_unit_pkg::*;
#(
  parameter int MDU_LAT = 4,
  parameter int CNT_W   = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  hazard_unit_if.slave hz,
  output mdu_state_e   o_dbg_state
);

  logic             w_busy;
  logic [REG_W-1:0] w_pend_rd;
  logic             w_load_haz;
  logic             w_mdu_haz;
  logic             w_stall;
  logic [CNT_W-1:0] r_stall_cycles;

  mdu_tracker #(.MDU_LAT(MDU_LAT)) u_mdu (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_start  (hz.mdu_start),
    .i_rd     (hz.mdu_rd),
    .o_busy   (w_busy),
    .o_pend_rd(w_pend_rd),
    .o_done   (hz.mdu_done),
    .o_rd_wb  (hz.mdu_rd_wb),
    .o_overrun(hz.mdu_overrun),
    .o_state  (o_dbg_state)
  );

  assign w_load_haz = hz.id_valid && hz.memRead_ex && hz.regWrite_ex &&
                      src_hit(hz.rd_ex, hz.rs_id, hz.rt_id, hz.uses_rs, hz.uses_rt);

  // A busy MDU blocks both readers of its result and any further MDU op.
  assign w_mdu_haz = hz.id_valid && w_busy &&
                     (src_hit(w_pend_rd, hz.rs_id, hz.rt_id, hz.uses_rs, hz.uses_rt) ||
                      hz.id_is_mdu);

  assign w_stall = (w_load_haz || w_mdu_haz) && !hz.flush;

  assign hz.stall_pc    = w_stall;
  assign hz.stall_ifid  = w_stall;
  assign hz.bubble_idex = w_stall || hz.flush;
  assign hz.mdu_busy    = w_busy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cycles <= '0;
    end else if (w_stall && (r_stall_cycles != {CNT_W{1'b1}})) begin
      r_stall_cycles <= r_stall_cycles + CNT_W'(1);
    end
  end

  assign hz.stall_cycles = r_stall_cycles;

endmodule

// File: tb/tb_hazard_unit.sv
module tb_hazard_unit;
  import hazard_unit_pkg::*;

  localparam int MDU_LAT = 4;
  localparam int CNT_W   = 4;

  logic       clk;
  logic       rst_n;
  mdu_state_e dbg_state;

  int n_tests;
  int n_fail;

  hazard_unit_if #(.CNT_W(CNT_W)) hz ();

  hazard_unit #(.MDU_LAT(MDU_LAT), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .hz         (hz.slave),
    .o_dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // checker
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // drivers
  task automatic clr_inputs();
    hz.id_valid    = 1'b0;
    hz.rs_id       = 5'd0;
    hz.rt_id       = 5'd0;
    hz.uses_rs     = 1'b0;
    hz.uses_rt     = 1'b0;
    hz.id_is_mdu   = 1'b0;
    hz.memRead_ex  = 1'b0;
    hz.regWrite_ex = 1'b0;
    hz.rd_ex       = 5'd0;
    hz.mdu_start   = 1'b0;
    hz.mdu_rd      = 5'd0;
    hz.flush       = 1'b0;
  endtask

  // Advance to just after the next rising edge: start of a new cycle.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_load(input logic [4:0] rd);
    hz.memRead_ex  = 1'b1;
    hz.regWrite_ex = 1'b1;
    hz.rd_ex       = rd;
  endtask

  task automatic set_id_rs(input logic [4:0] rs);
    hz.id_valid = 1'b1;
    hz.uses_rs  = 1'b1;
    hz.rs_id    = rs;
  endtask

  task automatic chk_stall(input string tag, input logic s, input logic b);
    #1;
    check({tag, "_stall_pc"},   32'(hz.stall_pc),    32'(s));
    check({tag, "_stall_ifid"}, 32'(hz.stall_ifid),  32'(s));
    check({tag, "_bubble"},     32'(hz.bubble_idex), 32'(b));
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clr_inputs();
    step();
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst_n   = 1'b1;
    clr_inputs();
    #2;

    // ---------------- reset state ----------------
    rst_n = 1'b0;
    #2;
    check("rst_busy",    32'(hz.mdu_busy),     32'd0);
    check("rst_done",    32'(hz.mdu_done),     32'd0);
    check("rst_rd_wb",   32'(hz.mdu_rd_wb),    32'd0);
    check("rst_overrun", 32'(hz.mdu_overrun),  32'd0);
    check("rst_cnt",     32'(hz.stall_cycles), 32'd0);
    check("rst_state",   32'(dbg_state),       32'(MDU_IDLE));
    chk_stall("rst", 1'b0, 1'b0);
    hz.flush = 1'b1;
    chk_stall("rst_flush", 1'b0, 1'b1);
    do_reset();

    // ---------------- load-use ----------------
    step();
    set_load(5'd5);
    set_id_rs(5'd5);
    chk_stall("lu", 1'b1, 1'b1);
    check("lu_cnt0", 32'(hz.stall_cycles), 32'd0);
    step();
    hz.memRead_ex  = 1'b0;  // load has moved on to MEM
    hz.regWrite_ex = 1'b0;
    chk_stall("lu_next", 1'b0, 1'b0);
    check("lu_cnt1", 32'(hz.stall_cycles), 32'd1);

    step();
    clr_inputs();
    set_load(5'd0);
    set_id_rs(5'd0);
    chk_stall("lu_r0", 1'b0, 1'b0);
    step();
    clr_inputs();
    set_load(5'd5);
    hz.id_valid = 1'b1;
    hz.rs_id    = 5'd5;
    hz.uses_rs  = 1'b0;
    chk_stall("lu_nouse", 1'b0, 1'b0);
    step();
    clr_inputs();
    set_load(5'd7);
    hz.id_valid = 1'b1;
    hz.uses_rt  = 1'b1;
    hz.rt_id    = 5'd7;
    chk_stall("lu_rt", 1'b1, 1'b1);
    step();
    clr_inputs();
    set_load(5'd5);
    hz.rs_id   = 5'd5;
    hz.uses_rs = 1'b1;
    chk_stall("lu_noid", 1'b0, 1'b0);
    check("lu_cnt2", 32'(hz.stall_cycles), 32'd2);

    // ---------------- flush priority ----------------
    step();
    clr_inputs();
    set_load(5'd5);
    set_id_rs(5'd5);
    hz.flush = 1'b1;
    chk_stall("fl", 1'b0, 1'b1);
    step();
    clr_inputs();
    #1;
    check("fl_cnt", 32'(hz.stall_cycles), 32'd2);

    // ---------------- MDU dependency ----------------
    hz.mdu_start = 1'b1;
    hz.mdu_rd    = 5'd9;
    step();                               // edge t
    hz.mdu_start = 1'b0;
    hz.id_valid  = 1'b1;
    hz.uses_rt   = 1'b1;
    hz.rt_id     = 5'd9;
    for (int k = 1; k <= 5; k++) begin
      if (k > 1) step();
      chk_stall($sformatf("md_t%0d", k), k <= 4, k <= 4);
      check($sformatf("md_busy_t%0d", k), 32'(hz.mdu_busy), 32'(k <= 4));
      check($sformatf("md_done_t%0d", k), 32'(hz.mdu_done), 32'(k == 4));
    end
    check("md_rd_wb", 32'(hz.mdu_rd_wb), 32'd9);
    check("md_cnt",   32'(hz.stall_cycles), 32'd6);

    // ---------------- structural hazard + overrun ----------------
    clr_inputs();
    hz.mdu_start = 1'b1;
    hz.mdu_rd    = 5'd3;
    step();                               // t+1
    clr_inputs();
    hz.id_valid  = 1'b1;
    hz.id_is_mdu = 1'b1;
    chk_stall("st_t1", 1'b1, 1'b1);
    step();                               // t+2: force a second start
    check("st_ovr0", 32'(hz.mdu_overrun), 32'd0);
    hz.mdu_start = 1'b1;
    hz.mdu_rd    = 5'd12;
    step();                               // t+3
    hz.mdu_start = 1'b0;
    chk_stall("st_t3", 1'b1, 1'b1);
    check("st_ovr1", 32'(hz.mdu_overrun), 32'd1);
    check("st_done3", 32'(hz.mdu_done), 32'd0);
    step();                               // t+4
    #1;
    check("st_done4", 32'(hz.mdu_done),  32'd1);
    check("st_rd_wb", 32'(hz.mdu_rd_wb), 32'd3);
    step();                               // t+5
    chk_stall("st_t5", 1'b0, 1'b0);
    check("st_busy5", 32'(hz.mdu_busy), 32'd0);
    check("st_cnt",   32'(hz.stall_cycles), 32'd10);

    // ---------------- flush during BUSY, double hazard counts once ----------------
    clr_inputs();
    hz.mdu_start = 1'b1;
    hz.mdu_rd    = 5'd7;
    step();                               // t+1: flushed
    clr_inputs();
    set_id_rs(5'd7);
    hz.flush = 1'b1;
    chk_stall("fb_t1", 1'b0, 1'b1);
    step();                               // t+2: load and MDU hazard together
    hz.flush = 1'b0;
    set_load(5'd7);
    chk_stall("fb_t2", 1'b1, 1'b1);
    step();                               // t+3
    hz.memRead_ex  = 1'b0;
    hz.regWrite_ex = 1'b0;
    chk_stall("fb_t3", 1'b1, 1'b1);
    step();                               // t+4: flushed, done still fires
    hz.flush = 1'b1;
    chk_stall("fb_t4", 1'b0, 1'b1);
    check("fb_done",  32'(hz.mdu_done),  32'd1);
    check("fb_rd_wb", 32'(hz.mdu_rd_wb), 32'd7);
    step();
    clr_inputs();
    #1;
    check("fb_busy5", 32'(hz.mdu_busy),     32'd0);
    check("fb_cnt",   32'(hz.stall_cycles), 32'd12);
    check("fb_ovr",   32'(hz.mdu_overrun),  32'd1);

    // ---------------- reset mid-op ----------------
    hz.mdu_start = 1'b1;
    hz.mdu_rd    = 5'd9;
    step();                               // t+1
    hz.mdu_start = 1'b0;
    step();                               // t+2
    rst_n = 1'b0;
    #1;
    check("rm_busy",  32'(hz.mdu_busy),     32'd0);
    check("rm_done",  32'(hz.mdu_done),     32'd0);
    check("rm_cnt",   32'(hz.stall_cycles), 32'd0);
    check("rm_ovr",   32'(hz.mdu_overrun),  32'd0);
    check("rm_state", 32'(dbg_state),       32'(MDU_IDLE));
    step();
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      check($sformatf("rm_nodone%0d", k), 32'(hz.mdu_done), 32'd0);
    end

    // ---------------- mdu_rd == 0, back-to-back start after done ----------------
    hz.mdu_start = 1'b1;
    hz.mdu_rd    = 5'd0;
    step();                               // t+1
    hz.mdu_start = 1'b0;
    set_id_rs(5'd0);
    chk_stall("z_t1", 1'b0, 1'b0);
    check("z_busy", 32'(hz.mdu_busy), 32'd1);
    step();
    step();
    step();                               // t+4
    #1;
    check("z_done",  32'(hz.mdu_done),  32'd1);
    check("z_rd_wb", 32'(hz.mdu_rd_wb), 32'd0);
    step();                               // t+5: idle, start accepted
    clr_inputs();
    hz.mdu_start = 1'b1;
    hz.mdu_rd    = 5'd4;
    step();
    hz.mdu_start = 1'b0;
    #1;
    check("bb_busy", 32'(hz.mdu_busy),    32'd1);
    check("bb_ovr",  32'(hz.mdu_overrun), 32'd0);
    check("bb_state", 32'(dbg_state),     32'(MDU_BUSY));

    // ---------------- saturation (CNT_W = 4) ----------------
    do_reset();
    step();
    set_load(5'd5);
    set_id_rs(5'd5);
    for (int k = 1; k <= 20; k++) begin
      step();
      if (k == 14 || k == 15 || k == 20)
        check($sformatf("sat_%0d", k), 32'(hz.stall_cycles), (k < 15) ? 32'(k) : 32'd15);
    end
    clr_inputs();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
